// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and FSM states for the data memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 19;
  typedef enum logic {IDLE, ACCESS} state_t;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: two requester ports plus the single memory port
interface data_mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
);
  logic req0, req1, we0, we1, ack0, ack1;
  logic [ADDR_W-1:0] addr0, addr1, memAddress;
  logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1;
  logic [DATA_W-1:0] memDataIn, memDataOut;
  logic memRead, memWrite;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memDataOut,
    output ack0, ack1, rdata0, rdata1, memAddress, memDataIn, memRead, memWrite
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memDataOut,
    input  ack0, ack1, rdata0, rdata1, memAddress, memDataIn, memRead, memWrite
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; a tie goes to the requester not granted last
module rr_arbiter2 (
  input  logic [1:0] eligible,
  input  logic       lastGrant,
  output logic       grantValid,
  output logic       grantId
);
  import mem_arb_pkg::*;
  always_comb begin
    grantValid = |eligible;
    grantId    = &eligible ? ~lastGrant : eligible[1];
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data memory port between load/store and loader, one registered access at a time
module data_mem_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input logic clk,
  input logic rst,
  data_mem_arbiter_if.slave bus
);
  import mem_arb_pkg::*;
  state_t state, state_nx;
  logic last_grant, grant_valid, grant_id, g_we, g_id;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic [1:0] ack;
  logic [DATA_W-1:0] rdata [2];
  // a requester being acked is masked so its still-high req is not re-granted
  rr_arbiter2 u_arb (
    .eligible  ({bus.req1 & ~ack[1], bus.req0 & ~ack[0]}),
    .lastGrant (last_grant),
    .grantValid(grant_valid),
    .grantId   (grant_id)
  );
  always_comb begin
    state_nx     = state == ACCESS ? IDLE : (grant_valid ? ACCESS : IDLE);
    bus.memRead  = state == ACCESS && !g_we;
    bus.memWrite = state == ACCESS && g_we;
  end
  assign bus.memAddress = g_addr;
  assign bus.memDataIn  = g_data;
  assign bus.ack0       = ack[0];
  assign bus.ack1       = ack[1];
  assign bus.rdata0     = rdata[0];
  assign bus.rdata1     = rdata[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ack        <= '0;
      rdata[0]   <= '0;
      rdata[1]   <= '0;
      last_grant <= 1'b1;
      g_we       <= 1'b0;
      g_id       <= 1'b0;
      g_addr     <= '0;
      g_data     <= '0;
    end else begin
      ack <= state == ACCESS ? (g_id ? 2'b10 : 2'b01) : 2'b00;
      if (state == ACCESS && !g_we) rdata[g_id] <= bus.memDataOut;
      if (state == IDLE && grant_valid) begin
        g_id       <= grant_id;
        last_grant <= grant_id;
        g_we       <= grant_id ? bus.we1 : bus.we0;
        g_addr     <= grant_id ? bus.addr1 : bus.addr0;
        g_data     <= grant_id ? bus.wdata1 : bus.wdata0;
      end
    end
  a_excl: assert property (@(posedge clk) disable iff (rst) !(bus.memRead && bus.memWrite));
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and randomized checks of the arbiter against a memory model and access rules
module tb_data_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  data_mem_arbiter_if bus ();
  data_mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [18:0] mem [256];
  logic [18:0] exp_mem [256];
  logic pl_en = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [18:0] pl_data = '0;
  always @(posedge clk)
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.memWrite) mem[bus.memAddress[7:0]] <= bus.memDataIn;
  assign bus.memDataOut = mem[bus.memAddress[7:0]];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      check("excl", 32'(bus.memRead & bus.memWrite), 0);
      check("ack_both", 32'(bus.ack0 & bus.ack1), 0);
    end
  task automatic set_req(input int id, input logic r, input logic w, input logic [18:0] a, input logic [18:0] d);
    if (id == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask
  function automatic logic ack_of(input int id);
    return id == 0 ? bus.ack0 : bus.ack1;
  endfunction
  function automatic logic [18:0] rdata_of(input int id);
    return id == 0 ? bus.rdata0 : bus.rdata1;
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic preload(input logic [7:0] a, input logic [18:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    exp_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask
  task automatic access(input int id, input logic w, input logic [18:0] a, input logic [18:0] d,
                        output logic [18:0] rd, output int lat);
    set_req(id, 1, w, a, d);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack_of(id) && lat < 20);
    check("ack_seen", 32'(ack_of(id)), 1);
    rd = rdata_of(id);
    set_req(id, 0, w, a, d);
  endtask
  task automatic rand_agent(input int id);
    logic w;
    logic [18:0] a, d, prev, rd;
    int lat;
    repeat (25) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w = 1'($urandom_range(0, 1));
      a = 19'($urandom_range(0, 15));
      d = 19'($urandom);
      prev = rdata_of(id);
      access(id, w, a, d, rd, lat);
      check("rand_lat", 32'(lat >= 2 && lat <= 4), 1);
      if (w) begin
        check("rand_wr_hold", rd, prev);
        exp_mem[a[7:0]] = d;
      end else check("rand_rd", rd, exp_mem[a[7:0]]);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [18:0] rd, rd1;
    int lat, lat1, n, start;
    int ids [8];
    int at [8];
    do_reset();
    check("rst_ack0", 32'(bus.ack0), 0);
    check("rst_ack1", 32'(bus.ack1), 0);
    check("rst_rdata0", bus.rdata0, 0);
    check("rst_rdata1", bus.rdata1, 0);
    check("rst_addr", bus.memAddress, 0);
    check("rst_din", bus.memDataIn, 0);
    repeat (5) begin
      @(negedge clk);
      check("idle_rw", 32'({bus.memRead, bus.memWrite}), 0);
    end
    // single write then read back
    set_req(0, 1, 1, 19'h00010, 19'h5A5A5);
    @(negedge clk);
    check("wr_memWrite", 32'(bus.memWrite), 1);
    check("wr_memRead", 32'(bus.memRead), 0);
    check("wr_addr", bus.memAddress, 19'h00010);
    check("wr_din", bus.memDataIn, 19'h5A5A5);
    check("wr_noack_yet", 32'(bus.ack0), 0);
    @(negedge clk);
    check("wr_ack0", 32'(bus.ack0), 1);
    check("wr_rdata_keep", bus.rdata0, 0);
    set_req(0, 0, 1, 19'h00010, 19'h5A5A5);
    check("wr_mem", mem[8'h10], 19'h5A5A5);
    @(negedge clk);
    check("ack_pulse", 32'(bus.ack0), 0);
    check("hold_addr", bus.memAddress, 19'h00010);
    access(0, 0, 19'h00010, 0, rd, lat);
    check("rd_lat", lat, 2);
    check("rd_data", rd, 19'h5A5A5);
    repeat (2) @(negedge clk);
    check("rd_hold", bus.rdata0, 19'h5A5A5);
    // simultaneous reads after reset: requester 0 wins the tie
    do_reset();
    check("rst2_rdata0", bus.rdata0, 0);
    preload(8'h01, 19'h11111);
    preload(8'h02, 19'h22222);
    fork
      access(0, 0, 19'h00001, 0, rd, lat);
      access(1, 0, 19'h00002, 0, rd1, lat1);
    join
    check("tie_lat0", lat, 2);
    check("tie_rd0", rd, 19'h11111);
    check("tie_lat1", lat1, 4);
    check("tie_rd1", rd1, 19'h22222);
    // both hold requests continuously: grants must alternate every 2 cycles
    @(negedge clk);
    set_req(0, 1, 0, 19'h00001, 0);
    set_req(1, 1, 0, 19'h00002, 0);
    start = cyc;
    n = 0;
    for (int k = 0; k < 40 && n < 8; k++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        ids[n] = 32'(bus.ack1);
        at[n] = cyc;
        check("alt_rdata", bus.ack1 ? bus.rdata1 : bus.rdata0, bus.ack1 ? 19'h22222 : 19'h11111);
        n++;
      end
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    check("alt_count", n, 8);
    for (int i = 0; i < n; i++) begin
      check("alt_id", ids[i], i % 2);
      check("alt_gap", at[i] - (i == 0 ? start : at[i-1]), 2);
    end
    repeat (4) @(negedge clk);
    // reset asserted in the middle of a write access
    preload(8'h20, 19'h12345);
    set_req(1, 1, 1, 19'h00020, 19'h7FFFF);
    @(negedge clk);
    check("mid_wr_on", 32'(bus.memWrite), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_wr_drop", 32'(bus.memWrite), 0);
    check("mid_rd_drop", 32'(bus.memRead), 0);
    @(negedge clk);
    check("mid_mem_kept", mem[8'h20], 19'h12345);
    check("mid_no_ack", 32'(bus.ack1), 0);
    set_req(1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_ack1", 32'(bus.ack1), 0);
      check("post_rst_rw", 32'({bus.memRead, bus.memWrite}), 0);
    end
    access(1, 0, 19'h00020, 0, rd1, lat1);
    check("post_rst_lat", lat1, 2);
    check("post_rst_rd", rd1, 19'h12345);
    // back-to-back reads by requester 0 alone
    preload(8'h03, 19'h33333);
    set_req(0, 1, 0, 19'h00003, 0);
    start = cyc;
    n = 0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      @(negedge clk);
      if (bus.ack0) begin
        at[n] = cyc;
        check("b2b_rdata", bus.rdata0, 19'h33333);
        n++;
      end
    end
    set_req(0, 0, 0, 0, 0);
    check("b2b_count", n, 3);
    for (int i = 0; i < n; i++) check("b2b_time", at[i] - start, 2 + 3 * i);
    check("b2b_rdata1", bus.rdata1, 19'h12345);
    repeat (3) @(negedge clk);
    // randomized concurrent traffic against the reference memory
    for (int i = 0; i < 16; i++) preload(8'(i), 19'($urandom));
    fork
      rand_agent(0);
      rand_agent(1);
    join
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
